rnn_cell_engine: RTL and testbench

Parametrised successor to the fixed 64×32 recurrent engine: computes a single-layer Elman RNN, h_t = act(b + W_x·x_t + W_h·h_{t-1}), over a memory-resident timestep count. Hidden size, input width, data width, fraction bits and address width are parameters. A run-time activation mode selects hard-tanh or clipped ReLU. A done pulse is added. The engine sits between the host input stream (idata/i_en) and the shared weight/result SRAM (msel/maddr).

---
 rtl/rnn_cell_engine.sv | 264 ++++++++++++++++++++++++++
 tb/tb_rnn_cell_engine.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rnn_cell_engine.sv
// Single-layer Elman RNN engine: streams bias/W_x/W_h from SRAM, accumulates one
// hidden unit at a time, saturates it and writes h_t back for every timestep.
module rnn_cell_engine #(
    parameter int HID  = 64,
    parameter int XW   = 32,
    parameter int DW   = 20,
    parameter int FRAC = 16,
    parameter int ACC  = 44,
    parameter int AW   = 17
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ready,
    input  logic          act_mode,
    input  logic [XW-1:0] idata,
    input  logic [DW-1:0] mdata_r,
    output logic          busy,
    output logic          done,
    output logic          i_en,
    output logic          mce,
    output logic [2:0]    msel,
    output logic [AW-1:0] maddr,
    output logic [DW-1:0] mdata_w
);

    localparam int HW = $clog2(HID);
    localparam int XI = $clog2(XW);
    localparam int IW = (XI > HW) ? XI : HW;
    localparam int CW = $clog2((XW > HID) ? XW : HID) + 1;
    localparam int RW = ACC - FRAC;

    localparam logic [2:0] SEL_CFG  = 3'b100;
    localparam logic [2:0] SEL_BIAS = 3'b001;
    localparam logic [2:0] SEL_WX   = 3'b000;
    localparam logic [2:0] SEL_WH   = 3'b010;
    localparam logic [2:0] SEL_HOUT = 3'b101;

    // Half an output LSB at accumulator scale: rounds half toward +inf.
    localparam logic signed [ACC-1:0] HALF      = ACC'(1) <<< (FRAC - 1);
    localparam logic signed [RW-1:0]  ONE_R     = RW'(1) <<< FRAC;
    localparam logic signed [RW-1:0]  NEG_ONE_R = -ONE_R;

    typedef enum logic [3:0] {
        S_IDLE, S_CFG, S_CFG_WAIT, S_INPUT, S_BIAS, S_WX, S_WH,
        S_DRAIN1, S_DRAIN2, S_WRITE, S_FIN
    } state_t;

    typedef enum logic [1:0] {RD_NONE, RD_BIAS, RD_WX, RD_WH} rd_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   i_q, i_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   t_q, t_d;
    logic [DW-1:0]   tcount_q, tcount_d;
    logic            mode_q, mode_d;
    logic            start, copy_h;

    rd_t             rd_kind_q, rd_kind_d;
    logic [IW-1:0]   rd_idx_q, rd_idx_d;
    logic            ien_q;
    logic [XW-1:0]   x_q;

    logic signed [ACC-1:0]  acc_q, acc_d;
    logic signed [DW-1:0]   rdata_s;
    logic signed [ACC-1:0]  wide_term;
    logic signed [2*DW-1:0] prod;
    logic signed [ACC-1:0]  rounded;
    logic signed [RW-1:0]   r_full, sat;
    logic [DW-1:0]          res_q, res_d;

    logic signed [DW-1:0]   h_prev_q [HID];
    logic signed [DW-1:0]   shadow_q [HID];

    assign rdata_s = mdata_r;
    assign mdata_w = res_q;

    // NOTE: every output and next-state is defaulted first so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        cnt_d     = cnt_q;
        t_d       = t_q;
        tcount_d  = tcount_q;
        mode_d    = mode_q;
        start     = 1'b0;
        copy_h    = 1'b0;
        rd_kind_d = RD_NONE;
        rd_idx_d  = IW'(cnt_q);
        busy      = 1'b0;
        done      = 1'b0;
        i_en      = 1'b0;
        mce       = 1'b0;
        msel      = SEL_CFG;
        maddr     = '0;

        case (state_q)
            S_IDLE, S_FIN: begin
                done = (state_q == S_FIN);
                if (ready) begin
                    state_d = S_CFG;
                    mode_d  = act_mode;
                    start   = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CFG: begin
                busy    = 1'b1;
                mce     = 1'b1;
                state_d = S_CFG_WAIT;
            end
            S_CFG_WAIT: begin
                busy     = 1'b1;
                tcount_d = mdata_r;
                t_d      = '0;
                state_d  = (mdata_r == '0) ? S_FIN : S_INPUT;
            end
            S_INPUT: begin
                busy    = 1'b1;
                i_en    = 1'b1;
                i_d     = '0;
                state_d = S_BIAS;
            end
            S_BIAS: begin
                busy      = 1'b1;
                mce       = 1'b1;
                msel      = SEL_BIAS;
                maddr     = AW'(i_q);
                rd_kind_d = RD_BIAS;
                cnt_d     = '0;
                state_d   = S_WX;
            end
            S_WX: begin
                busy      = 1'b1;
                mce       = 1'b1;
                msel      = SEL_WX;
                maddr     = AW'(i_q) * AW'(XW) + AW'(cnt_q);
                rd_kind_d = RD_WX;
                if (cnt_q == CW'(XW - 1)) begin
                    cnt_d   = '0;
                    state_d = S_WH;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WH: begin
                busy      = 1'b1;
                mce       = 1'b1;
                msel      = SEL_WH;
                maddr     = (AW'(i_q) << HW) + AW'(cnt_q);
                rd_kind_d = RD_WH;
                if (cnt_q == CW'(HID - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DRAIN1: begin
                busy    = 1'b1;
                state_d = S_DRAIN2;
            end
            S_DRAIN2: begin
                busy    = 1'b1;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                busy  = 1'b1;
                mce   = 1'b1;
                msel  = SEL_HOUT;
                maddr = (AW'(t_q) << HW) | AW'(i_q);
                if (i_q == HW'(HID - 1)) begin
                    copy_h = 1'b1;
                    i_d    = '0;
                    if (t_q == tcount_q - DW'(1)) begin
                        state_d = S_FIN;
                    end else begin
                        t_d     = t_q + DW'(1);
                        state_d = S_INPUT;
                    end
                end else begin
                    i_d     = i_q + HW'(1);
                    state_d = S_BIAS;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            i_q      <= '0;
            cnt_q    <= '0;
            t_q      <= '0;
            tcount_q <= '0;
            mode_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            cnt_q    <= cnt_d;
            t_q      <= t_d;
            tcount_q <= tcount_d;
            mode_q   <= mode_d;
        end
    end

    // Read data returns one cycle after the request; rd_kind_q/rd_idx_q tag it.
    always_comb begin
        wide_term = ACC'(rdata_s) <<< FRAC;
        prod      = rdata_s * h_prev_q[rd_idx_q[HW-1:0]];
        acc_d     = acc_q;
        case (rd_kind_q)
            RD_BIAS: acc_d = wide_term;
            RD_WX:   if (x_q[rd_idx_q[XI-1:0]]) acc_d = acc_q + wide_term;
            RD_WH:   acc_d = acc_q + ACC'(prod);
            default: acc_d = acc_q;
        endcase
    end

    always_comb begin
        rounded = acc_q + HALF;
        r_full  = RW'(rounded >>> FRAC);
        if (mode_q) begin
            sat = r_full[RW-1] ? '0 : ((r_full > ONE_R) ? ONE_R : r_full);
        end else begin
            sat = (r_full > ONE_R) ? ONE_R :
                  ((r_full < NEG_ONE_R) ? NEG_ONE_R : r_full);
        end
        res_d = DW'(sat);
    end

    // NOTE: the h buffers are small register arrays and must start at zero, so they are reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q     <= '0;
            res_q     <= '0;
            x_q       <= '0;
            ien_q     <= 1'b0;
            rd_kind_q <= RD_NONE;
            rd_idx_q  <= '0;
            for (int k = 0; k < HID; k++) begin
                h_prev_q[k] <= '0;
                shadow_q[k] <= '0;
            end
        end else begin
            acc_q     <= acc_d;
            ien_q     <= i_en;
            rd_kind_q <= rd_kind_d;
            rd_idx_q  <= rd_idx_d;
            if (ien_q) x_q <= idata;
            if (state_q == S_DRAIN2) begin
                res_q       <= res_d;
                shadow_q[i_q] <= res_d;
            end
            if (start) begin
                for (int k = 0; k < HID; k++) h_prev_q[k] <= '0;
            end else if (copy_h) begin
                h_prev_q <= shadow_q;
            end
        end
    end

endmodule

// File: tb/tb_rnn_cell_engine.sv
// Self-checking bench for rnn_cell_engine: SRAM responder, host input driver and
// an arithmetic reference model of the RNN recurrence.
module tb_rnn_cell_engine;

    localparam int HID  = 4;
    localparam int XW   = 4;
    localparam int DW   = 20;
    localparam int FRAC = 16;
    localparam int ACC  = 44;
    localparam int AW   = 17;

    logic          clk = 1'b0;
    logic          reset;
    logic          ready;
    logic          act_mode;
    logic [XW-1:0] idata = '0;
    logic [DW-1:0] mdata_r = '0;
    logic          busy, done, i_en, mce;
    logic [2:0]    msel;
    logic [AW-1:0] maddr;
    logic [DW-1:0] mdata_w;

    rnn_cell_engine #(
        .HID(HID), .XW(XW), .DW(DW), .FRAC(FRAC), .ACC(ACC), .AW(AW)
    ) dut (
        .clk(clk), .reset(reset), .ready(ready), .act_mode(act_mode),
        .idata(idata), .mdata_r(mdata_r), .busy(busy), .done(done),
        .i_en(i_en), .mce(mce), .msel(msel), .maddr(maddr), .mdata_w(mdata_w)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory image and per-timestep input vectors
    int            cfg_t;
    int            bias_m [HID];
    int            wx_m   [HID][XW];
    int            wh_m   [HID][HID];
    logic [XW-1:0] xs     [8];

    logic [DW-1:0] rd_pend = '0;
    int            ien_cnt = 0;
    int            ien_base = 0;
    logic [AW-1:0] wr_a [$];
    logic [DW-1:0] wr_d [$];

    int     exp_a [$];
    longint exp_d [$];

    function automatic logic [DW-1:0] mem_read(input logic [2:0] sel, input logic [AW-1:0] a);
        int ai;
        ai = int'(a);
        case (sel)
            3'b100:  return (ai == 0) ? DW'(cfg_t) : '0;
            3'b001:  return DW'(bias_m[ai % HID]);
            3'b000:  return DW'(wx_m[(ai / XW) % HID][ai % XW]);
            3'b010:  return DW'(wh_m[(ai / HID) % HID][ai % HID]);
            default: return DW'($urandom);
        endcase
    endfunction

    always @(negedge clk) begin
        rd_pend = (mce && msel != 3'b101) ? mem_read(msel, maddr) : DW'($urandom);
        if (mce && msel == 3'b101) begin
            wr_a.push_back(maddr);
            wr_d.push_back(mdata_w);
        end
        if (i_en) begin
            idata = xs[(ien_cnt - ien_base) % 8];
            ien_cnt++;
        end
    end

    always @(posedge clk) mdata_r <= rd_pend;

    // Reference: h_t = sat(round(b + sum x*Wx + sum Wh*h_{t-1})) in plain integers.
    function automatic void model();
        longint hp [HID];
        longint hn [HID];
        longint one, acc, r;
        one = longint'(1) << FRAC;
        exp_a.delete();
        exp_d.delete();
        for (int k = 0; k < HID; k++) hp[k] = 0;
        for (int t = 0; t < cfg_t; t++) begin
            for (int i = 0; i < HID; i++) begin
                acc = longint'(bias_m[i]) * one;
                for (int j = 0; j < XW; j++)
                    if (xs[t][j]) acc += longint'(wx_m[i][j]) * one;
                for (int k = 0; k < HID; k++)
                    acc += longint'(wh_m[i][k]) * hp[k];
                r = (acc + one / 2) >>> FRAC;
                if (act_mode) begin
                    if (r < 0) r = 0;
                    if (r > one) r = one;
                end else begin
                    if (r > one) r = one;
                    if (r < -one) r = -one;
                end
                hn[i] = r;
                exp_a.push_back((t * HID + i) % (1 << AW));
                exp_d.push_back(r);
            end
            for (int k = 0; k < HID; k++) hp[k] = hn[k];
        end
    endfunction

    function automatic int rnd(input int mag);
        return int'($urandom_range(2 * mag)) - mag;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < HID; i++) begin
            bias_m[i] = 0;
            for (int j = 0; j < XW; j++) wx_m[i][j] = 0;
            for (int k = 0; k < HID; k++) wh_m[i][k] = 0;
        end
        for (int n = 0; n < 8; n++) xs[n] = '0;
    endtask

    task automatic rand_mem(input int t);
        cfg_t = t;
        for (int i = 0; i < HID; i++) begin
            bias_m[i] = rnd('h14000);
            for (int j = 0; j < XW; j++) wx_m[i][j] = rnd('h8000);
            for (int k = 0; k < HID; k++) wh_m[i][k] = rnd('h10000);
        end
        for (int n = 0; n < 8; n++) xs[n] = XW'($urandom);
    endtask

    task automatic start_run(input string name);
        @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check({name, "/start_busy"}, busy, 1);
        check({name, "/start_mce"}, mce, 1);
        check({name, "/start_msel"}, msel, 3'b100);
        check({name, "/start_maddr"}, maddr, 0);
    endtask

    task automatic run_case(input string name);
        int            wb, cyc, exp_cyc;
        bit            seen;
        logic [DW-1:0] e;
        model();
        wb       = wr_a.size();
        ien_base = ien_cnt;
        exp_cyc  = 2 + cfg_t * (1 + HID * (XW + HID + 4));
        start_run(name);
        cyc  = 1;
        seen = 1'b0;
        for (int n = 0; n < 5000 && !seen; n++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (busy) cyc++;
        end
        check({name, "/done_seen"}, seen, 1);
        check({name, "/busy_cycles"}, cyc, exp_cyc);
        check({name, "/busy_at_done"}, busy, 0);
        check({name, "/mce_at_done"}, mce, 0);
        check({name, "/msel_at_done"}, msel, 3'b100);
        @(negedge clk);
        check({name, "/done_width"}, done, 0);
        check({name, "/ien_count"}, ien_cnt - ien_base, cfg_t);
        check({name, "/write_count"}, wr_a.size() - wb, exp_a.size());
        for (int n = 0; n < exp_a.size() && wb + n < wr_a.size(); n++) begin
            e = DW'(exp_d[n]);
            check({name, "/waddr"}, wr_a[wb + n], exp_a[n]);
            check({name, "/wdata"}, wr_d[wb + n], e);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "/busy"}, busy, 0);
        check({name, "/done"}, done, 0);
        check({name, "/i_en"}, i_en, 0);
        check({name, "/mce"}, mce, 0);
        check({name, "/msel"}, msel, 3'b100);
        check({name, "/maddr"}, maddr, 0);
        check({name, "/mdata_w"}, mdata_w, 0);
    endtask

    initial begin
        int  wb;
        bit  busy_seen;
        reset    = 1'b1;
        ready    = 1'b0;
        act_mode = 1'b0;
        cfg_t    = 0;
        clear_mem();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;

        cfg_t = 0;
        run_case("t0");

        // ready held high: a second run starts the cycle after done
        ready = 1'b1;
        @(negedge clk);
        check("b2b/busy0", busy, 1);
        @(negedge clk);
        check("b2b/busy1", busy, 1);
        @(negedge clk);
        check("b2b/done", done, 1);
        @(negedge clk);
        check("b2b/restart", busy, 1);
        ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("b2b/done2", done, 1);
        @(negedge clk);

        // reset wins over ready
        reset = 1'b1;
        ready = 1'b1;
        @(negedge clk);
        check("rst_ready/busy", busy, 0);
        reset = 1'b0;
        ready = 1'b0;

        clear_mem();
        cfg_t = 1;
        for (int i = 0; i < HID; i++) bias_m[i] = 'h08000;
        run_case("half");

        for (int i = 0; i < HID; i++) bias_m[i] = 'h30000;
        run_case("sat_pos");
        for (int i = 0; i < HID; i++) bias_m[i] = -'h30000;
        run_case("sat_neg");
        act_mode = 1'b1;
        run_case("relu_neg");
        act_mode = 1'b0;

        clear_mem();
        cfg_t = 2;
        for (int i = 0; i < HID; i++) begin
            wh_m[i][i] = 'h10000;
            for (int j = 0; j < XW; j++) wx_m[i][j] = 'h04000;
        end
        xs[0] = 4'b0011;
        xs[1] = 4'b0011;
        run_case("recur");

        clear_mem();
        cfg_t = 2;
        for (int i = 0; i < HID; i++) begin
            wh_m[i][i] = 1;
            wx_m[i][0] = (i < 2) ? 'h08000 : -'h08000;
        end
        xs[0] = 4'b0001;
        xs[1] = 4'b0000;
        run_case("round");

        for (int n = 0; n < 6; n++) begin
            rand_mem(1 + int'($urandom_range(2)));
            act_mode = 1'($urandom);
            run_case("rand");
        end

        // Abort during W_h reads of neuron 2 in timestep 1, then rerun clean
        rand_mem(2);
        act_mode = 1'b0;
        wb       = wr_a.size();
        ien_base = ien_cnt;
        start_run("abort");
        repeat (82) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("abort");
        check("abort/partial_writes", wr_a.size() - wb, 6);
        reset = 1'b0;
        wb        = wr_a.size();
        busy_seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (busy) busy_seen = 1'b1;
        end
        check("abort/no_writes", wr_a.size() - wb, 0);
        check("abort/stays_idle", busy_seen, 0);
        run_case("after_abort");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
